// File: rtl/calc_accumulator.sv
// Sequential accumulator core of the calculator: add, subtract, clear and (when
// CALC_MUL_EN is defined) a W-iteration shift-add multiply on a signed W-bit accumulator.
module calc_accumulator #(
    parameter int W = 11
) (
    input  logic                clock,
    input  logic                reset,
    input  logic signed [W-1:0] operand,
    input  logic [1:0]          opsel,
    input  logic                enter,
    output logic signed [W-1:0] acc,
    output logic                encoding,
    output logic                overflow,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    // The extra top bit disagrees with the W-bit sign exactly when the result did not fit.
    function automatic logic add_ovf(input logic [W:0] r);
        return r[W] != r[W-1];
    endfunction

    logic signed [W:0] sum_w;
    logic signed [W:0] dif_w;
    logic              accept;

    assign sum_w    = {acc[W-1], acc} + {operand[W-1], operand};
    assign dif_w    = {acc[W-1], acc} - {operand[W-1], operand};
    assign encoding = 1'b1;

`ifdef CALC_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;
    localparam int CW = $clog2(W);
    localparam logic [2*W-1:0] MAX_POS = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [2*W-1:0] MAX_NEG = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
        return v[W-1] ? (~v + 1'b1) : v;
    endfunction

    // Negative results may reach one step further than positive ones.
    function automatic logic mul_ovf(input logic [2*W-1:0] mag, input logic neg);
        return neg ? (mag > MAX_NEG) : (mag > MAX_POS);
    endfunction

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  mcand;
    logic [2*W-1:0]  prod_nxt;
    logic [2*W-1:0]  res;
    logic [W-1:0]    mplr;
    logic            sign;
    logic            last;

    assign accept   = enter && (state == IDLE);
    assign last     = (cnt == CW'(W-1));
    assign prod_nxt = prod + (mplr[0] ? mcand : '0);
    assign res      = sign ? (~prod_nxt + 1'b1) : prod_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && opsel == OP_MUL) state_nxt = MUL;
            MUL:     if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MUL);
    end
`else
    assign accept = enter;
    assign busy   = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef CALC_MUL_EN
            cnt      <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplr     <= '0;
            sign     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                error <= 1'b0;
                case (opsel)
                    OP_ADD: begin
                        acc      <= sum_w[W-1:0];
                        overflow <= add_ovf(sum_w);
                        done     <= 1'b1;
                    end
                    OP_SUB: begin
                        acc      <= dif_w[W-1:0];
                        overflow <= add_ovf(dif_w);
                        done     <= 1'b1;
                    end
                    OP_MUL: begin
`ifdef CALC_MUL_EN
                        mcand <= {{W{1'b0}}, magnitude(acc)};
                        mplr  <= magnitude(operand);
                        sign  <= acc[W-1] ^ operand[W-1];
                        prod  <= '0;
                        cnt   <= '0;
`else
                        error <= 1'b1;
                        done  <= 1'b1;
`endif
                    end
                    OP_CLR: begin
                        acc      <= '0;
                        overflow <= 1'b0;
                        done     <= 1'b1;
                    end
                endcase
            end
`ifdef CALC_MUL_EN
            // Acc is written only on the last iteration so no partial product is ever shown.
            else if (state == MUL) begin
                prod  <= prod_nxt;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    acc      <= res[W-1:0];
                    overflow <= mul_ovf(prod_nxt, sign);
                    done     <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_calc_accumulator.sv
// Scoreboard bench for calc_accumulator; exercises the multiply path when CALC_MUL_EN is defined.
module tb_calc_accumulator;

    localparam int W = 11;
`ifdef CALC_MUL_EN
    localparam int MUL_LAT = W;
`else
    localparam int MUL_LAT = 0;
`endif

    logic                clock = 1'b0;
    logic                reset;
    logic signed [W-1:0] operand;
    logic [1:0]          opsel;
    logic                enter;
    logic signed [W-1:0] acc;
    logic                encoding, overflow, busy, done, error;

    calc_accumulator #(.W(W)) dut (
        .clock(clock), .reset(reset), .operand(operand), .opsel(opsel), .enter(enter),
        .acc(acc), .encoding(encoding), .overflow(overflow), .busy(busy), .done(done),
        .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int acc;
        int ovf;
        int err;
        int lat;
        int issue;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   m_acc = 0, m_ovf = 0, m_err = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("acc", acc, e.acc);
                check("overflow", overflow, e.ovf);
                check("error", error, e.err);
                check("latency", cyc - e.issue, e.lat);
            end
        end
    end

    function automatic int wrap(input int t);
        logic signed [W-1:0] v;
        v = t[W-1:0];
        return int'(v);
    endfunction

    function automatic int out_of_range(input int t);
        return (t > 1023 || t < -1024) ? 1 : 0;
    endfunction

    // Update the reference model and drive one Enter pulse.
    task automatic issue(input logic [1:0] op, input int val);
        exp_t e;
        int   t;
        int   lat;
        lat = 0;
        case (op)
            2'b00: begin t = m_acc + val; m_ovf = out_of_range(t); m_acc = wrap(t); m_err = 0; end
            2'b01: begin t = m_acc - val; m_ovf = out_of_range(t); m_acc = wrap(t); m_err = 0; end
            2'b10: begin
`ifdef CALC_MUL_EN
                t = m_acc * val; m_ovf = out_of_range(t); m_acc = wrap(t); m_err = 0;
`else
                m_err = 1;
`endif
                lat = MUL_LAT;
            end
            default: begin m_acc = 0; m_ovf = 0; m_err = 0; end
        endcase
        @(posedge clock);
        #1;
        e = '{acc: m_acc, ovf: m_ovf, err: m_err, lat: lat, issue: cyc + 1};
        sb.push_back(e);
        enter   = 1'b1;
        opsel   = op;
        operand = val[W-1:0];
        @(posedge clock);
        #1;
        enter = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clock);
        if (sb.size() != 0) begin
            check("timeout_pending", sb.size(), 0);
            sb.delete();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic [1:0] op, input int val);
        issue(op, val);
        drain();
    endtask

    initial begin
        reset = 1'b1; enter = 1'b0; opsel = 2'b00; operand = '0;
        repeat (2) @(negedge clock);
        check("rst_acc", acc, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("encoding", encoding, 1);
        @(posedge clock);
        #1 reset = 1'b0;

        do_op(2'b00, 500);
        do_op(2'b00, 600);
        check("acc_minus948", acc, -948);
        do_op(2'b11, 0);
        do_op(2'b01, 5);
        do_op(2'b01, 1023);
        do_op(2'b11, 0);
        do_op(2'b00, -1024);
        do_op(2'b01, 1);

`ifdef CALC_MUL_EN
        do_op(2'b11, 0);
        do_op(2'b00, -25);
        busy_cnt = 0;
        do_op(2'b10, 40);
        check("busy_cycles", busy_cnt, W);
        check("acc_minus1000", acc, -1000);
        do_op(2'b11, 0);
        do_op(2'b00, 100);
        do_op(2'b10, 20);
        do_op(2'b11, 0);
        do_op(2'b00, -1024);
        do_op(2'b10, 1);
        do_op(2'b10, -1);
        do_op(2'b10, 0);

        // Enter during MUL (clear request plus new operand) must be ignored.
        do_op(2'b11, 0);
        do_op(2'b00, 7);
        issue(2'b10, 9);
        repeat (2) @(posedge clock);
        #1;
        enter = 1'b1; opsel = 2'b11; operand = 11'sd100;
        @(posedge clock);
        #1 enter = 1'b0;
        drain();
        check("acc_63", acc, 63);

        // Reset mid-multiply aborts without a Done pulse.
        do_op(2'b11, 0);
        do_op(2'b00, 5);
        issue(2'b10, 3);
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("abort_acc", acc, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        sb.delete();
        m_acc = 0; m_ovf = 0; m_err = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (W + 3) @(posedge clock);
        #1;
        do_op(2'b00, 7);
        check("acc_after_abort", acc, 7);
`else
        do_op(2'b11, 0);
        do_op(2'b00, 12);
        busy_cnt = 0;
        do_op(2'b10, 3);
        check("nomul_busy", busy_cnt, 0);
        check("nomul_acc", acc, 12);
        check("nomul_error", error, 1);
        do_op(2'b00, 1);
        check("nomul_acc13", acc, 13);
        check("nomul_error_clr", error, 0);
`endif

        for (int i = 0; i < 12; i++) begin
            logic [1:0] op;
            int         val;
            op  = 2'($urandom_range(0, 3));
            val = (op == 2'b10) ? int'($urandom_range(0, 80)) - 40
                                : int'($urandom_range(0, 2047)) - 1024;
            do_op(op, val);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
